jtkiwi_shram: RTL and testbench
===============================

# jtkiwi_shram

Shared-RAM arbiter for the Kiwi sound/sub-CPU work RAM. It owns the 8 kB dual-accessed RAM and serves two requesters: the main CPU port and the sound-CPU port at D000–EFFF. The sound-CPU side uses the `ram_cs` / `cpu_rnw` / `mshramen` convention. While the RAM is not available to the sound CPU, the block asserts `mshramen`. The sound CPU gates it with its own `ram_cs` to stall its clock enable.

## Interface
Parameters:
- `AW`, 13, RAM address width (2^AW bytes).
- `SNDTO`, 64, sound-hold timeout in `clk` cycles (used only with `JTKIWI_SHRAM_TO_EN`).

Ports:
- `clk`  in  1  system clock.
- `comb_rstn`  in  1  reset, asynchronous, active-low.
- `main_cs`  in  1  main CPU request; held high until `main_ok`.
- `main_rnw`  in  1  main CPU read (1) / write (0).
- `main_addr`  in  AW  main CPU address.
- `main_din`  in  8  main CPU write data.
- `main_dout`  out  8  main CPU read data; valid while `main_ok`.
- `main_ok`  out  1  main access complete; high until `main_cs` falls.
- `snd_cs`  in  1  sound CPU RAM select (`ram_cs`).
- `snd_rnw`  in  1  sound CPU strobe, active-low write (`cpu_rnw`); low for one `clk` per write.
- `snd_addr`  in  AW  sound CPU address (`ram_addr`).
- `snd_din`  in  8  sound CPU write data (`ram_din`).
- `snd_dout`  out  8  sound CPU read data (`ram_dout`).
- `mshramen`  out  1  RAM owned or claimed by the main side; the sound CPU must stall while `mshramen & snd_cs`.

## Operation
- Internal RAM: 2^AW × 8, one port, synchronous read with 1-cycle latency, write on the rising edge of `clk`.
- State machine with states IDLE, MAIN1, MAIN2, SND.
  - **IDLE:**
    - If a main request is pending (`main_cs & ~main_done`), go to MAIN1. The main side has priority when both requesters are active in the same cycle.
    - Otherwise, if `snd_cs` is high, go to SND.
  - **MAIN1:**
    - RAM address is `main_addr`.
    - Write `main_din` if `main_rnw` is 0.
    - Next state is MAIN2.
  - **MAIN2:**
    - Register `main_dout` from the RAM output.
    - Set `main_done`.
    - Go to IDLE.
  - **SND:**
    - RAM address is `snd_addr`.
    - Write `snd_din` on every cycle with `snd_rnw` = 0.
    - `snd_dout` follows the RAM output every cycle.
    - `snd_vld` sets on the second SND cycle.
    - Go to IDLE when `snd_cs` is low; this clears `snd_vld`.
    - A pending main request waits; it does not preempt SND (but see Configuration).
- `main_ok = main_done`. `main_done` clears on the first cycle `main_cs` is low. A new main request therefore needs `main_cs` low for at least one cycle.
- `mshramen = ~(st == SND & snd_vld)`. It is high in IDLE/MAIN, so a sound access is always stalled until its read data is valid.
- A write with `snd_rnw` = 0 during SND before `snd_vld` is still performed. The sound CPU will not issue one, because it is stalled.

## Timing
- Reset values: state IDLE, `main_done` 0, `snd_vld` 0, `main_dout` 0, `snd_dout` 0, `main_ok` 0, `mshramen` 1.
- Main access, idle RAM: `main_cs` sampled high at cycle n gives MAIN1 at n+1, MAIN2 at n+2, and `main_ok` high from n+3.
- Sound access, idle RAM: `snd_cs` sampled high at cycle n gives SND at n+1, `snd_vld` at n+2, and `mshramen` low from n+2.
- Sound access blocked by main: SND is entered on the cycle after MAIN2. Worst-case extra stall is 3 cycles.
- Main access blocked by sound: waits until `snd_cs` falls, then 1 IDLE cycle, then the normal 3-cycle latency.
- Reset asserted mid-access: any in-progress write either completes on that edge or is dropped. RAM contents are not cleared. `main_ok` drops.

## Configuration
- `JTKIWI_SHRAM_TO_EN` defined: a counter runs in SND while a main request is pending.
  - When it reaches `SNDTO`, the block forces SND→IDLE, then MAIN1 follows, and `snd_vld` clears so `mshramen` rises.
  - After the main access, SND is re-entered if `snd_cs` is still high.
  - The counter clears whenever the state leaves SND.
- Undefined: no timeout; the sound side keeps the RAM for as long as `snd_cs` is high.

## Test plan
- Main write `addr` 0x0123 = 0x5A, then main read 0x0123 → `main_ok` 3 cycles after each request and `main_dout` = 0x5A.
- Sound write 0x1FFF = 0xC3 (one-cycle `snd_rnw` low after `mshramen` falls), then main read 0x1FFF → 0xC3; `mshramen` falls exactly 2 cycles after `snd_cs`.
- `main_cs` and `snd_cs` rise in the same cycle → MAIN first; `mshramen` stays high for 5 cycles, then falls; `main_ok` precedes `snd_vld`.
- `main_cs` held high after `main_ok` → no second access; drop for 1 cycle and raise again → second access completes.
- With `JTKIWI_SHRAM_TO_EN` and `SNDTO` = 8: `snd_cs` held high and a main request arriving in SND → `mshramen` rises 8 cycles later, main completes, then `mshramen` falls again. Without the macro, main waits until `snd_cs` drops.
- Assert `comb_rstn` low during MAIN1 → `main_ok` 0, `mshramen` 1, state IDLE; after release a normal access works.

Source files
------------

// File: rtl/jtkiwi_shram.sv
// Shared 8 kB work RAM arbitrated between the main CPU and the sound CPU.
// Define JTKIWI_SHRAM_TO_EN to let a waiting main request evict the sound CPU after SNDTO cycles.
module jtkiwi_shram #(
    parameter int AW    = 13,
    parameter int SNDTO = 64
) (
    input  logic          clk,
    input  logic          comb_rstn,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_din,
    output logic [7:0]    main_dout,
    output logic          main_ok,
    input  logic          snd_cs,
    input  logic          snd_rnw,
    input  logic [AW-1:0] snd_addr,
    input  logic [7:0]    snd_din,
    output logic [7:0]    snd_dout,
    output logic          mshramen
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        MAIN1,
        MAIN2,
        SND
    } st_t;

    st_t           r_st, w_nx;
    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_ramq;
    logic [7:0]    r_main_dout;
    logic [7:0]    r_snd_hold;
    logic          r_main_done;
    logic          r_snd_vld;
    logic          w_main_pend;
    logic          w_to;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_din;

    assign w_main_pend = main_cs & ~r_main_done;

    always_comb begin
        w_nx = r_st;
        case (r_st)
            IDLE: begin
                if (w_main_pend)
                    w_nx = MAIN1;
                else if (snd_cs)
                    w_nx = SND;
            end
            MAIN1:   w_nx = MAIN2;
            MAIN2:   w_nx = IDLE;
            SND:     if (~snd_cs | w_to) w_nx = IDLE;
            default: w_nx = IDLE;
        endcase
    end

    // The single RAM port belongs to the sound CPU only while in SND
    assign w_addr = (r_st == SND) ? snd_addr : main_addr;
    assign w_din  = (r_st == SND) ? snd_din  : main_din;
    assign w_we   = ((r_st == MAIN1) & ~main_rnw) | ((r_st == SND) & ~snd_rnw);

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_addr] <= w_din;
        r_ramq <= r_mem[w_addr];
    end

    always_ff @(posedge clk or negedge comb_rstn) begin
        if (!comb_rstn) begin
            r_st        <= IDLE;
            r_main_done <= 1'b0;
            r_main_dout <= 8'd0;
            r_snd_vld   <= 1'b0;
            r_snd_hold  <= 8'd0;
        end else begin
            r_st       <= w_nx;
            r_snd_vld  <= (r_st == SND) & (w_nx == SND);
            r_snd_hold <= snd_dout;
            if (r_st == MAIN2) begin
                r_main_dout <= r_ramq;
                r_main_done <= 1'b1;
            end else if (~main_cs) begin
                r_main_done <= 1'b0;
            end
        end
    end

`ifdef JTKIWI_SHRAM_TO_EN
    localparam int            CW      = $clog2(SNDTO + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(SNDTO - 1);

    logic [CW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge comb_rstn) begin
        if (!comb_rstn)
            r_to_cnt <= '0;
        else if (r_st != SND)
            r_to_cnt <= '0;
        else if (w_main_pend)
            r_to_cnt <= r_to_cnt + CW'(1);
    end

    assign w_to = w_main_pend & (r_to_cnt == TO_LAST);
`else
    assign w_to = 1'b0;
`endif

    // Sound data tracks the RAM live in SND and holds its last value elsewhere
    assign snd_dout  = (r_st == SND) ? r_ramq : r_snd_hold;
    assign main_dout = r_main_dout;
    assign main_ok   = r_main_done;
    assign mshramen  = ~((r_st == SND) & r_snd_vld);

endmodule

// File: tb/tb_jtkiwi_shram.sv
// Randomized self-checking bench for jtkiwi_shram against an array model of the RAM
// and the access latencies of both CPU ports.
module tb_jtkiwi_shram;

    localparam int AW = 13;
`ifdef JTKIWI_SHRAM_TO_EN
    localparam int TB_SNDTO = 8;
`else
    localparam int TB_SNDTO = 64;
`endif

    logic          clk;
    logic          comb_rstn;
    logic          main_cs;
    logic          main_rnw;
    logic [AW-1:0] main_addr;
    logic [7:0]    main_din;
    logic [7:0]    main_dout;
    logic          main_ok;
    logic          snd_cs;
    logic          snd_rnw;
    logic [AW-1:0] snd_addr;
    logic [7:0]    snd_din;
    logic [7:0]    snd_dout;
    logic          mshramen;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    modelMem [1 << AW];
    logic [AW-1:0] writtenQ [$];

    jtkiwi_shram #(.AW(AW), .SNDTO(TB_SNDTO)) dut (
        .clk       (clk),
        .comb_rstn (comb_rstn),
        .main_cs   (main_cs),
        .main_rnw  (main_rnw),
        .main_addr (main_addr),
        .main_din  (main_din),
        .main_dout (main_dout),
        .main_ok   (main_ok),
        .snd_cs    (snd_cs),
        .snd_rnw   (snd_rnw),
        .snd_addr  (snd_addr),
        .snd_din   (snd_din),
        .snd_dout  (snd_dout),
        .mshramen  (mshramen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] randAddr();
        return AW'($urandom_range(0, (1 << AW) - 1));
    endfunction

    function automatic logic [AW-1:0] pickWritten();
        return writtenQ[$urandom_range(0, writtenQ.size() - 1)];
    endfunction

    // Full main-port handshake; lat counts edges from request to main_ok
    task automatic main_access(input logic rnw, input logic [AW-1:0] addr, input logic [7:0] din,
                               output logic [7:0] dout, output int lat);
        main_rnw  = rnw;
        main_addr = addr;
        main_din  = din;
        main_cs   = 1'b1;
        lat       = 0;
        while (main_ok !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        if (main_ok !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL main_timeout addr=%h main_ok=%b expected 1", addr, main_ok);
        end
        dout     = main_dout;
        main_cs  = 1'b0;
        main_rnw = 1'b1;
        tick();
    endtask

    // Full sound-port access; lat counts edges from snd_cs to mshramen falling
    task automatic snd_access(input logic wr, input logic [AW-1:0] addr, input logic [7:0] din,
                              output logic [7:0] dout, output int lat);
        snd_addr = addr;
        snd_rnw  = 1'b1;
        snd_cs   = 1'b1;
        lat      = 0;
        while (mshramen !== 1'b0 && lat < 50) begin
            tick();
            lat++;
        end
        if (mshramen !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL snd_timeout addr=%h mshramen=%b expected 0", addr, mshramen);
        end
        dout = snd_dout;
        if (wr) begin
            snd_din = din;
            snd_rnw = 1'b0;
            tick();
            snd_rnw = 1'b1;
        end
        snd_cs = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        comb_rstn = 1'b0;
        main_cs   = 1'b0;
        main_rnw  = 1'b1;
        main_addr = '0;
        main_din  = '0;
        snd_cs    = 1'b0;
        snd_rnw   = 1'b1;
        snd_addr  = '0;
        snd_din   = '0;
        repeat (3) tick();
        checks++;
        if (main_ok !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_main_ok got=%b expected=0", main_ok);
        end
        checks++;
        if (mshramen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mshramen got=%b expected=1", mshramen);
        end
        checks++;
        if (main_dout !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_main_dout got=%h expected=00", main_dout);
        end
        checks++;
        if (snd_dout !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_snd_dout got=%h expected=00", snd_dout);
        end
        comb_rstn = 1'b1;
        tick();
    endtask

    task automatic test_main_rw();
        logic [7:0]    d;
        logic [AW-1:0] addrs [4];
        int            lat;
        main_access(1'b0, 13'h0123, 8'h5A, d, lat);
        modelMem[13'h0123] = 8'h5A;
        writtenQ.push_back(13'h0123);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("[TB] FAIL main_wr_latency got=%0d expected=3", lat);
        end
        main_access(1'b1, 13'h0123, 8'h00, d, lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("[TB] FAIL main_rd_latency got=%0d expected=3", lat);
        end
        checks++;
        if (d !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL main_rd_0123 got=%h expected=5a", d);
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] v;
            addrs[i] = randAddr();
            v = 8'($urandom);
            main_access(1'b0, addrs[i], v, d, lat);
            modelMem[addrs[i]] = v;
            writtenQ.push_back(addrs[i]);
        end
        for (int i = 0; i < 4; i++) begin
            main_access(1'b1, addrs[i], 8'h00, d, lat);
            checks++;
            if (d !== modelMem[addrs[i]] || lat !== 3) begin
                failures++;
                $display("[TB] FAIL main_rand_rd addr=%h got=%h lat=%0d expected=%h lat=3",
                         addrs[i], d, lat, modelMem[addrs[i]]);
            end
        end
    endtask

    task automatic test_snd_rw();
        logic [7:0]    d;
        logic [AW-1:0] a;
        int            lat;
        snd_access(1'b1, 13'h1FFF, 8'hC3, d, lat);
        modelMem[13'h1FFF] = 8'hC3;
        writtenQ.push_back(13'h1FFF);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("[TB] FAIL snd_wr_latency got=%0d expected=2", lat);
        end
        main_access(1'b1, 13'h1FFF, 8'h00, d, lat);
        checks++;
        if (d !== 8'hC3) begin
            failures++;
            $display("[TB] FAIL main_rd_1fff got=%h expected=c3", d);
        end
        for (int i = 0; i < 4; i++) begin
            a = pickWritten();
            snd_access(1'b0, a, 8'h00, d, lat);
            checks++;
            if (d !== modelMem[a] || lat !== 2) begin
                failures++;
                $display("[TB] FAIL snd_rand_rd addr=%h got=%h lat=%0d expected=%h lat=2",
                         a, d, lat, modelMem[a]);
            end
        end
    endtask

    // Both requesters in the same cycle: main goes first, sound waits three extra cycles
    task automatic test_simultaneous();
        logic [AW-1:0] a1, a2;
        logic [7:0]    md, sd;
        int            okTick, fallTick;
        a1 = pickWritten();
        a2 = pickWritten();
        main_rnw  = 1'b1;
        main_addr = a1;
        main_cs   = 1'b1;
        snd_rnw   = 1'b1;
        snd_addr  = a2;
        snd_cs    = 1'b1;
        okTick    = 0;
        fallTick  = 0;
        md        = 8'h00;
        sd        = 8'h00;
        for (int k = 1; k <= 30 && fallTick == 0; k++) begin
            tick();
            if (main_ok === 1'b1 && okTick == 0) begin
                okTick  = k;
                md      = main_dout;
                main_cs = 1'b0;
            end
            if (mshramen === 1'b0) begin
                fallTick = k;
                sd       = snd_dout;
            end
        end
        checks++;
        if (okTick !== 3) begin
            failures++;
            $display("[TB] FAIL simul_main_ok_tick got=%0d expected=3", okTick);
        end
        checks++;
        if (fallTick !== 5) begin
            failures++;
            $display("[TB] FAIL simul_mshramen_fall got=%0d expected=5", fallTick);
        end
        checks++;
        if (md !== modelMem[a1] || sd !== modelMem[a2]) begin
            failures++;
            $display("[TB] FAIL simul_data main=%h snd=%h expected main=%h snd=%h",
                     md, sd, modelMem[a1], modelMem[a2]);
        end
        main_cs = 1'b0;
        snd_cs  = 1'b0;
        tick();
    endtask

    // main_cs held past main_ok must not start a second access
    task automatic test_hold_cs();
        logic [AW-1:0] a, b;
        logic [7:0]    d, sd;
        int            lat, okLost, fall;
        a = pickWritten();
        b = pickWritten();
        main_rnw  = 1'b1;
        main_addr = a;
        main_cs   = 1'b1;
        lat       = 0;
        while (main_ok !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 3 || main_dout !== modelMem[a]) begin
            failures++;
            $display("[TB] FAIL hold_first lat=%0d data=%h expected lat=3 data=%h",
                     lat, main_dout, modelMem[a]);
        end
        snd_addr = b;
        snd_rnw  = 1'b1;
        snd_cs   = 1'b1;
        okLost   = 0;
        fall     = 0;
        sd       = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (main_ok !== 1'b1)
                okLost++;
            if (mshramen === 1'b0 && fall == 0) begin
                fall = k;
                sd   = snd_dout;
            end
        end
        checks++;
        if (okLost !== 0) begin
            failures++;
            $display("[TB] FAIL hold_ok_kept lost=%0d expected=0", okLost);
        end
        checks++;
        if (fall !== 2 || sd !== modelMem[b]) begin
            failures++;
            $display("[TB] FAIL hold_snd_access fall=%0d data=%h expected fall=2 data=%h",
                     fall, sd, modelMem[b]);
        end
        snd_cs = 1'b0;
        tick();
        main_cs = 1'b0;
        tick();
        checks++;
        if (main_ok !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_ok_clear got=%b expected=0", main_ok);
        end
        main_access(1'b1, a, 8'h00, d, lat);
        checks++;
        if (lat !== 3 || d !== modelMem[a]) begin
            failures++;
            $display("[TB] FAIL hold_second lat=%0d data=%h expected lat=3 data=%h",
                     lat, d, modelMem[a]);
        end
    endtask

    // Main request arriving while the sound CPU owns the RAM
    task automatic test_blocked_main();
        logic [AW-1:0] a, b;
        int            k;
        a = pickWritten();
        b = pickWritten();
        snd_addr = a;
        snd_rnw  = 1'b1;
        snd_cs   = 1'b1;
        k        = 0;
        while (mshramen !== 1'b0 && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 2) begin
            failures++;
            $display("[TB] FAIL blk_snd_grant got=%0d expected=2", k);
        end
        main_rnw  = 1'b1;
        main_addr = b;
        main_cs   = 1'b1;
`ifdef JTKIWI_SHRAM_TO_EN
        k = 0;
        while (mshramen !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (k !== TB_SNDTO) begin
            failures++;
            $display("[TB] FAIL to_evict_tick got=%0d expected=%0d", k, TB_SNDTO);
        end
        while (main_ok !== 1'b1 && k < 80) begin
            tick();
            k++;
        end
        checks++;
        if (k !== TB_SNDTO + 3 || main_dout !== modelMem[b]) begin
            failures++;
            $display("[TB] FAIL to_main_done tick=%0d data=%h expected tick=%0d data=%h",
                     k, main_dout, TB_SNDTO + 3, modelMem[b]);
        end
        main_cs = 1'b0;
        k = 0;
        while (mshramen !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 2 || snd_dout !== modelMem[a]) begin
            failures++;
            $display("[TB] FAIL to_snd_regrant tick=%0d data=%h expected tick=2 data=%h",
                     k, snd_dout, modelMem[a]);
        end
        snd_cs = 1'b0;
        tick();
`else
        begin
            int hold, bad;
            hold = $urandom_range(4, 12);
            bad  = 0;
            repeat (hold) begin
                tick();
                if (mshramen !== 1'b0 || main_ok !== 1'b0)
                    bad++;
            end
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("[TB] FAIL blk_snd_kept bad_cycles=%0d expected=0", bad);
            end
        end
        snd_cs = 1'b0;
        k = 0;
        while (main_ok !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 4 || main_dout !== modelMem[b]) begin
            failures++;
            $display("[TB] FAIL blk_main_after_snd tick=%0d data=%h expected tick=4 data=%h",
                     k, main_dout, modelMem[b]);
        end
        main_cs = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            lat;
        a = pickWritten();
        main_rnw  = 1'b1;
        main_addr = a;
        main_cs   = 1'b1;
        tick();
        #2 comb_rstn = 1'b0;
        #1;
        checks++;
        if (main_ok !== 1'b0 || mshramen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs main_ok=%b mshramen=%b expected 0 1", main_ok, mshramen);
        end
        main_cs = 1'b0;
        tick();
        comb_rstn = 1'b1;
        tick();
        snd_access(1'b0, a, 8'h00, d, lat);
        checks++;
        if (lat !== 2 || d !== modelMem[a]) begin
            failures++;
            $display("[TB] FAIL rst_mid_snd lat=%0d data=%h expected lat=2 data=%h", lat, d, modelMem[a]);
        end
        main_access(1'b1, a, 8'h00, d, lat);
        checks++;
        if (lat !== 3 || d !== modelMem[a]) begin
            failures++;
            $display("[TB] FAIL rst_mid_main lat=%0d data=%h expected lat=3 data=%h", lat, d, modelMem[a]);
        end
        main_addr = pickWritten();
        main_cs   = 1'b1;
        repeat (3) tick();
        checks++;
        if (main_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_ok_pre got=%b expected=1", main_ok);
        end
        #2 comb_rstn = 1'b0;
        #1;
        checks++;
        if (main_ok !== 1'b0 || main_dout !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rst_ok_drop main_ok=%b main_dout=%h expected 0 00", main_ok, main_dout);
        end
        main_cs = 1'b0;
        tick();
        comb_rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_main_rw();
        test_snd_rw();
        test_simultaneous();
        test_hold_cs();
        test_blocked_main();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
